// File: rtl/ines_loader_if.sv
// ines_loader_if: iNES byte stream plus PRG/CHR BRAM port-B write bus.
// master = loader side; slave = stream source and BRAM side.
interface ines_loader_if;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] BRAM_PRG_addr;
   logic [31:0] BRAM_PRG_dout;
   logic        BRAM_PRG_en;
   logic [3:0]  BRAM_PRG_we;
   logic [31:0] BRAM_CHR_addr;
   logic [31:0] BRAM_CHR_dout;
   logic        BRAM_CHR_en;
   logic [3:0]  BRAM_CHR_we;

   modport master (
      input  s_data, s_valid,
      output s_ready,
      output BRAM_PRG_addr, BRAM_PRG_dout, BRAM_PRG_en, BRAM_PRG_we,
      output BRAM_CHR_addr, BRAM_CHR_dout, BRAM_CHR_en, BRAM_CHR_we
   );

   modport slave (
      output s_data, s_valid,
      input  s_ready,
      input  BRAM_PRG_addr, BRAM_PRG_dout, BRAM_PRG_en, BRAM_PRG_we,
      input  BRAM_CHR_addr, BRAM_CHR_dout, BRAM_CHR_en, BRAM_CHR_we
   );
endinterface

// File: rtl/ines_loader.sv
// ines_loader: parses an iNES header from a byte stream and packs PRG/CHR
// data into 32-bit BRAM writes; emits mapper_config and address masks.
// Ports: clk, rst_n (async low), start, bus (ines_loader_if.master: stream
// in, PRG/CHR BRAM writes out), mapper_config, PRG_mask, CHR_mask,
// PRGRAM_mask, done, error.
// Option: define INES_MAGIC_CHECK_EN to require "NES\x1A" in bytes 0..3.
module ines_loader #(
   parameter int PRG_AW = 15,
   parameter int CHR_AW = 13
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   ines_loader_if.master bus,
   output logic [31:0]   mapper_config,
   output logic [31:0]   PRG_mask,
   output logic [31:0]   CHR_mask,
   output logic [31:0]   PRGRAM_mask,
   output logic          done,
   output logic          error
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_TRAIN, S_PRG, S_CHR, S_DONE, S_ERR
   } state_t;

   localparam logic [31:0] PRG_MAX = 32'd1 << PRG_AW;
   localparam logic [31:0] CHR_MAX = 32'd1 << CHR_AW;

   // Round n up to a power of two, minus one (n > 0).
   function automatic logic [31:0] pow2_mask(input logic [31:0] n);
      logic [31:0] m;
      m = n - 32'd1;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      m = m | (m >> 16);
      return m;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [23:0] pack_q, pack_d;
   logic [7:0]  b4_q, b4_d, b5_q, b5_d;
   logic [7:0]  b6_q, b6_d, b8_q, b8_d;
   logic [3:0]  b7_q, b7_d;
   logic [31:0] prg_q, prg_d, chr_q, chr_d;
   logic [31:0] cfg_q, cfg_d, pm_q, pm_d;
   logic [31:0] cm_q, cm_d, rm_q, rm_d;
   logic        rdy_q, rdy_d, done_q, done_d;
   logic        err_q, err_d;
   logic        pen_q, pen_d, cen_q, cen_d;
   logic [31:0] pa_q, pa_d, pd_q, pd_d;
   logic [31:0] ca_q, ca_d, cd_q, cd_d;

   logic        hs;
   logic        bad;
   logic        last;
   logic [31:0] prg_n, chr_n, ram_n, word;
`ifdef INES_MAGIC_CHECK_EN
   logic        magic_q, magic_d, magic_hit;
   logic [7:0]  magic_exp;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pack_d  = pack_q;
      b4_d    = b4_q;
      b5_d    = b5_q;
      b6_d    = b6_q;
      b7_d    = b7_q;
      b8_d    = b8_q;
      prg_d   = prg_q;
      chr_d   = chr_q;
      cfg_d   = cfg_q;
      pm_d    = pm_q;
      cm_d    = cm_q;
      rm_d    = rm_q;
      pen_d   = 1'b0;
      cen_d   = 1'b0;
      pa_d    = pa_q;
      pd_d    = pd_q;
      ca_d    = ca_q;
      cd_d    = cd_q;
      hs      = bus.s_valid & rdy_q;
      word    = {bus.s_data, pack_q};
      prg_n   = {10'd0, b4_q, 14'd0};
      chr_n   = {11'd0, b5_q, 13'd0};
      ram_n   = (b8_q == 8'd0) ? 32'h2000 : {11'd0, b8_q, 13'd0};
      bad     = (b4_q == 8'd0) || (prg_n > PRG_MAX) || (chr_n > CHR_MAX);
      last    = 1'b0;
`ifdef INES_MAGIC_CHECK_EN
      magic_d   = magic_q;
      magic_hit = 1'b0;
      unique case (cnt_q[1:0])
         2'd0: magic_exp = 8'h4E;
         2'd1: magic_exp = 8'h45;
         2'd2: magic_exp = 8'h53;
         2'd3: magic_exp = 8'h1A;
         default: magic_exp = 8'h00;
      endcase
`endif

      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_HDR;
               cnt_d   = 32'd0;
               pack_d  = 24'd0;
`ifdef INES_MAGIC_CHECK_EN
               magic_d = 1'b1;
`endif
            end
         end
         S_HDR: begin
            if (hs) begin
               cnt_d = cnt_q + 32'd1;
               unique case (cnt_q[3:0])
                  4'd4:    b4_d = bus.s_data;
                  4'd5:    b5_d = bus.s_data;
                  4'd6:    b6_d = bus.s_data;
                  4'd7:    b7_d = bus.s_data[7:4];
                  4'd8:    b8_d = bus.s_data;
                  default: ;
               endcase
               // Bytes 4..8 are all latched by the 16th byte.
               if (cnt_q[3:0] == 4'd15) begin
                  cnt_d = 32'd0;
                  prg_d = prg_n;
                  chr_d = chr_n;
                  cfg_d = {16'd0, b7_q, b6_q[7:4], 3'd0,
                           (b5_q == 8'd0), b6_q[3:0]};
                  pm_d  = pow2_mask(prg_n);
                  cm_d  = (chr_n == 32'd0) ? 32'h1FFF : chr_n - 32'd1;
                  rm_d  = pow2_mask(ram_n);
                  if (bad)
                     state_d = S_ERR;
                  else if (b6_q[2])
                     state_d = S_TRAIN;
                  else
                     state_d = S_PRG;
               end
`ifdef INES_MAGIC_CHECK_EN
               if (cnt_q < 32'd4) begin
                  magic_hit = magic_q && (bus.s_data == magic_exp);
                  magic_d   = magic_hit;
                  if (cnt_q[1:0] == 2'd3 && !magic_hit)
                     state_d = S_ERR;
               end
`endif
            end
         end
         S_TRAIN: begin
            if (hs) begin
               cnt_d = cnt_q + 32'd1;
               if (cnt_q == 32'd511) begin
                  cnt_d   = 32'd0;
                  state_d = S_PRG;
               end
            end
         end
         S_PRG, S_CHR: begin
            if (hs) begin
               cnt_d = cnt_q + 32'd1;
               unique case (cnt_q[1:0])
                  2'd0: pack_d[7:0]   = bus.s_data;
                  2'd1: pack_d[15:8]  = bus.s_data;
                  2'd2: pack_d[23:16] = bus.s_data;
                  2'd3: begin
                     if (state_q == S_PRG) begin
                        pen_d = 1'b1;
                        pa_d  = {cnt_q[31:2], 2'b00};
                        pd_d  = word;
                     end else begin
                        cen_d = 1'b1;
                        ca_d  = {cnt_q[31:2], 2'b00};
                        cd_d  = word;
                     end
                  end
                  default: ;
               endcase
               if (state_q == S_PRG)
                  last = (cnt_q == prg_q - 32'd1);
               else
                  last = (cnt_q == chr_q - 32'd1);
               if (last) begin
                  cnt_d = 32'd0;
                  if (state_q == S_PRG && chr_q != 32'd0)
                     state_d = S_CHR;
                  else
                     state_d = S_DONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      rdy_d  = (state_d == S_HDR) || (state_d == S_TRAIN) ||
               (state_d == S_PRG) || (state_d == S_CHR);
      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pack_q  <= '0;
         b4_q    <= '0;
         b5_q    <= '0;
         b6_q    <= '0;
         b7_q    <= '0;
         b8_q    <= '0;
         prg_q   <= '0;
         chr_q   <= '0;
         cfg_q   <= '0;
         pm_q    <= '0;
         cm_q    <= '0;
         rm_q    <= '0;
         rdy_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         pen_q   <= 1'b0;
         cen_q   <= 1'b0;
         pa_q    <= '0;
         pd_q    <= '0;
         ca_q    <= '0;
         cd_q    <= '0;
`ifdef INES_MAGIC_CHECK_EN
         magic_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pack_q  <= pack_d;
         b4_q    <= b4_d;
         b5_q    <= b5_d;
         b6_q    <= b6_d;
         b7_q    <= b7_d;
         b8_q    <= b8_d;
         prg_q   <= prg_d;
         chr_q   <= chr_d;
         cfg_q   <= cfg_d;
         pm_q    <= pm_d;
         cm_q    <= cm_d;
         rm_q    <= rm_d;
         rdy_q   <= rdy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         pen_q   <= pen_d;
         cen_q   <= cen_d;
         pa_q    <= pa_d;
         pd_q    <= pd_d;
         ca_q    <= ca_d;
         cd_q    <= cd_d;
`ifdef INES_MAGIC_CHECK_EN
         magic_q <= magic_d;
`endif
      end
   end

   assign bus.s_ready       = rdy_q;
   assign bus.BRAM_PRG_addr = pa_q;
   assign bus.BRAM_PRG_dout = pd_q;
   assign bus.BRAM_PRG_en   = pen_q;
   assign bus.BRAM_PRG_we   = {4{pen_q}};
   assign bus.BRAM_CHR_addr = ca_q;
   assign bus.BRAM_CHR_dout = cd_q;
   assign bus.BRAM_CHR_en   = cen_q;
   assign bus.BRAM_CHR_we   = {4{cen_q}};
   assign mapper_config     = cfg_q;
   assign PRG_mask          = pm_q;
   assign CHR_mask          = cm_q;
   assign PRGRAM_mask       = rm_q;
   assign done              = done_q;
   assign error             = err_q;

endmodule
